// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and coordinate types.
// Constants only, so there is no latency and no backpressure.
package vga_pkg;
   localparam int COORD_W   = 10;
   localparam int MAX_TOTAL = 1 << COORD_W;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef logic [COORD_W-1:0] coord_t;
   // One bit wider than coord_t, so that a TOTAL of 1024 still compares correctly.
   typedef logic [COORD_W:0]   span_t;
endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one axis: count is registered; wrap, next_count and the sync/visible decodes are combinational.
// The decodes describe the value count takes on the next edge. The block advances whenever advance=1 and has no backpressure.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL,
   parameter int SYNC_START = H_VISIBLE + H_FRONT,
   parameter int SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC,
   parameter int VISIBLE    = H_VISIBLE
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   advance,
   output coord_t count,
   output coord_t next_count,
   output logic   wrap,
   output logic   in_sync,
   output logic   in_visible
);
   localparam coord_t LAST = coord_t'(TOTAL - 1);

   coord_t count_q;
   coord_t count_d;
   span_t  next_ext;

   assign wrap = advance && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (wrap) begin
         count_d = '0;
      end else if (advance) begin
         count_d = count_q + coord_t'(1);
      end
   end

   assign next_ext   = {1'b0, count_d};
   assign in_sync    = (next_ext >= span_t'(SYNC_START)) && (next_ext < span_t'(SYNC_END));
   assign in_visible = next_ext < span_t'(VISIBLE);
   assign next_count = count_d;
   assign count      = count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= LAST;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 sync generator: every output is registered and aligned with h_count/v_count; no backpressure.
// Define VGA_SYNC_LOOKAHEAD_EN to add the next_h/next_v/next_display_en look-ahead outputs.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int   H_FRONT   = vga_pkg::H_FRONT,
   parameter int   H_SYNC    = vga_pkg::H_SYNC,
   parameter int   H_BACK    = vga_pkg::H_BACK,
   parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int   V_FRONT   = vga_pkg::V_FRONT,
   parameter int   V_SYNC    = vga_pkg::V_SYNC,
   parameter int   V_BACK    = vga_pkg::V_BACK,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic       clock,
   input  logic       reset_n,
   output logic       hsync,
   output logic       vsync,
   output logic       display_en,
   output coord_t     h_count,
   output coord_t     v_count,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
`ifdef VGA_SYNC_LOOKAHEAD_EN
   ,
   output coord_t     next_h,
   output coord_t     next_v,
   output logic       next_display_en
`endif
);
   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   if (H_TOTAL > MAX_TOTAL) begin : g_h_total_illegal
      $fatal(1, "vga_sync_gen: H_TOTAL exceeds the 10-bit coordinate range");
   end
   if (V_TOTAL > MAX_TOTAL) begin : g_v_total_illegal
      $fatal(1, "vga_sync_gen: V_TOTAL exceeds the 10-bit coordinate range");
   end

   coord_t h_next, v_next;
   logic   h_wrap, v_wrap, h_in_sync, v_in_sync, h_in_vis, v_in_vis;

   vga_axis_counter #(
      .TOTAL(H_TOTAL), .SYNC_START(HS_START), .SYNC_END(HS_END), .VISIBLE(H_VISIBLE)
   ) u_h_axis (
      .clock(clock), .reset_n(reset_n), .advance(1'b1),
      .count(h_count), .next_count(h_next), .wrap(h_wrap),
      .in_sync(h_in_sync), .in_visible(h_in_vis)
   );

   vga_axis_counter #(
      .TOTAL(V_TOTAL), .SYNC_START(VS_START), .SYNC_END(VS_END), .VISIBLE(V_VISIBLE)
   ) u_v_axis (
      .clock(clock), .reset_n(reset_n), .advance(h_wrap),
      .count(v_count), .next_count(v_next), .wrap(v_wrap),
      .in_sync(v_in_sync), .in_visible(v_in_vis)
   );

   logic       hsync_q, vsync_q, display_en_q, line_start_q, frame_start_q, started_q;
   logic       hsync_d, vsync_d, display_en_d, line_start_d, frame_start_d;
   logic [7:0] frame_count_q, frame_count_d;

   // The first wrap after reset opens frame 0, so frame_count only counts once started_q is set.
   always_comb begin
      hsync_d       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      display_en_d  = h_in_vis && v_in_vis;
      line_start_d  = (h_next == '0);
      frame_start_d = line_start_d && (v_next == '0);
      frame_count_d = frame_count_q;
      if (v_wrap && started_q) begin
         frame_count_d = frame_count_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         display_en_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 8'd0;
         started_q     <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_en_q  <= display_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
         started_q     <= 1'b1;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_en  = display_en_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

`ifdef VGA_SYNC_LOOKAHEAD_EN
   assign next_h          = h_next;
   assign next_v          = v_next;
   assign next_display_en = display_en_d;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken timing (16x11 total) so that 256 frames fit in a short run.
// A per-cycle model queues the expected outputs, and counters measure line and frame timing.
module tb_vga_sync_gen;
   localparam int HV = 8, HF = 2, HS = 3, HB = 3;
   localparam int VV = 6, VF = 1, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int HSS = HV + HF, HSE = HV + HF + HS;
   localparam int VSS = VV + VF, VSE = VV + VF + VS;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       hsync, vsync, display_en, line_start, frame_start;
   logic [9:0] h_count, v_count;
   logic [7:0] frame_count;
`ifdef VGA_SYNC_LOOKAHEAD_EN
   logic [9:0] next_h, next_v;
   logic       next_display_en;
`endif

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut (
      .clock(clock), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
      .display_en(display_en), .h_count(h_count), .v_count(v_count),
      .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
`ifdef VGA_SYNC_LOOKAHEAD_EN
      , .next_h(next_h), .next_v(next_v), .next_display_en(next_display_en)
`endif
   );

   always #5 clock = ~clock;

   int   errors = 0;
   int   checks = 0;
   obs_t exp_q[$];
   int   mh, mv, mfc;
   bit   mstarted;
   int   cyc, de_hi, hs_lo, vs_lo, de_bad, ls_n, fs_n, last_ls, ls_per, last_fs, fs_per, fc_first_fs;

   function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                               input bit de, input bit ls, input bit fs, input int fc);
      obs_t o;
      o.h = 10'(h); o.v = 10'(v); o.hs = hs; o.vs = vs;
      o.de = de; o.ls = ls; o.fs = fs; o.fc = 8'(fc);
      return o;
   endfunction

   function automatic obs_t dut_obs();
      return mk(int'(h_count), int'(v_count), hsync, vsync, display_en,
                line_start, frame_start, int'(frame_count));
   endfunction

   function automatic obs_t model_obs();
      return mk(mh, mv, !(mh >= HSS && mh < HSE), !(mv >= VSS && mv < VSE),
                (mh < HV) && (mv < VV), mh == 0, (mh == 0) && (mv == 0), mfc);
   endfunction

   task automatic model_reset();
      mh = HT - 1; mv = VT - 1; mfc = 0; mstarted = 1'b0;
   endtask

   task automatic model_advance();
      if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv = 0;
            if (mstarted) mfc = (mfc + 1) % 256;
         end else begin
            mv = mv + 1;
         end
      end else begin
         mh = mh + 1;
      end
      mstarted = 1'b1;
   endtask

   task automatic clear_stats();
      cyc = 0; de_hi = 0; hs_lo = 0; vs_lo = 0; de_bad = 0;
      ls_n = 0; fs_n = 0; last_ls = -1; ls_per = 0; last_fs = -1; fs_per = 0; fc_first_fs = -1;
   endtask

   task automatic check_obs(input string tag, input obs_t got, input obs_t want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                tag, got.h, got.v, got.hs, got.vs, got.de, got.ls, got.fs, got.fc,
                want.h, want.v, want.hs, want.vs, want.de, want.ls, want.fs, want.fc);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic step(input string tag);
      obs_t got, want;
`ifdef VGA_SYNC_LOOKAHEAD_EN
      logic [20:0] la;
      la = {next_h, next_v, next_display_en};
`endif
      model_advance();
      exp_q.push_back(model_obs());
      @(posedge clock);
      #1;
      got  = dut_obs();
      want = exp_q.pop_front();
      check_obs(tag, got, want);
`ifdef VGA_SYNC_LOOKAHEAD_EN
      check_int({tag, "_lookahead"}, int'(la), int'({h_count, v_count, display_en}));
`endif
      cyc++;
      if (got.de) de_hi++;
      if (got.de && got.v >= 10'(VV)) de_bad++;
      if (!got.hs) hs_lo++;
      if (!got.vs) vs_lo++;
      if (got.ls) begin
         ls_n++;
         if (last_ls >= 0) ls_per = cyc - last_ls;
         last_ls = cyc;
      end
      if (got.fs) begin
         fs_n++;
         if (last_fs >= 0) fs_per = cyc - last_fs;
         else fc_first_fs = int'(got.fc);
         last_fs = cyc;
      end
   endtask

   initial begin
      int guard;
      reset_n = 1'b0;
      model_reset();
      clear_stats();
      repeat (5) @(posedge clock);
      #1;
      check_obs("reset_hold", dut_obs(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
`ifdef VGA_SYNC_LOOKAHEAD_EN
      check_int("reset_lookahead", int'({next_h, next_v, next_display_en}), int'({10'd0, 10'd0, 1'b1}));
`endif

      @(negedge clock);
      reset_n = 1'b1;
      step("first_edge");
      check_obs("first_edge_const", dut_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));

      clear_stats();
      repeat (2 * HT) step("line");
      check_int("line_de_cycles", de_hi, 2 * HV);
      check_int("line_hsync_low", hs_lo, 2 * HS);
      check_int("line_start_count", ls_n, 2);
      check_int("line_start_period", ls_per, HT);

      clear_stats();
      repeat (2 * FRAME) step("frame");
      check_int("frame_start_count", fs_n, 2);
      check_int("frame_start_period", fs_per, FRAME);
      check_int("frame_vsync_low", vs_lo, 2 * VS * HT);
      check_int("frame_de_cycles", de_hi, 2 * HV * VV);
      check_int("frame_de_outside", de_bad, 0);
      check_int("frame_count_first", fc_first_fs, 1);
      check_int("frame_count_two", int'(frame_count), 2);

      guard = 0;
      while (!(mfc == 255 && mh == HT - 1 && mv == VT - 1) && guard < 50000) begin
         step("run_to_255");
         guard++;
      end
      check_obs("corner_state", dut_obs(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 255));
      clear_stats();
      step("wrap_corner");
      check_obs("wrap_corner_const", dut_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));
      step("after_wrap");
      check_int("wrap_line_pulses", ls_n, 1);
      check_int("wrap_frame_pulses", fs_n, 1);

      guard = 0;
      while (!(mh == 5 && mv == 3) && guard < 2 * FRAME) begin
         step("run_to_mid");
         guard++;
      end
      check_obs("mid_state", dut_obs(), mk(5, 3, 1, 1, 1, 0, 0, 0));
      #2;
      reset_n = 1'b0;
      #1;
      check_obs("async_reset", dut_obs(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
`ifdef VGA_SYNC_LOOKAHEAD_EN
      check_int("async_reset_lookahead", int'({next_h, next_v, next_display_en}), int'({10'd0, 10'd0, 1'b1}));
`endif
      repeat (3) @(posedge clock);
      #1;
      check_obs("reset_held_edges", dut_obs(), mk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0));
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      step("restart");
      check_obs("restart_const", dut_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));
      repeat (FRAME + 3) step("post_restart");
      check_int("post_restart_frame_count", int'(frame_count), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
